// File: rtl/neuron_seq.sv
// Sequential neuron: bias + N_INPUTS signed weights in a register file, LANES inputs summed per cycle.
// Optional build macro NEURON_SAT_EN: each addition step saturates instead of wrapping.
module neuron_seq #(
   parameter int N_INPUTS = 9,
   parameter int W_WIDTH  = 8,
   parameter int LANES    = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // valid never waits on ready, and an unaccepted in_valid is simply dropped.
   input  logic                          w_we,
   input  logic [$clog2(N_INPUTS+1)-1:0] w_addr,
   input  logic [W_WIDTH-1:0]            w_data,
   output logic                          w_ready,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_INPUTS-1:0]           x,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [W_WIDTH-1:0]            sum,
   output logic                          predict,
   output logic [1:0]                    dbg_state_o
);

   localparam int AW = $clog2(N_INPUTS + 1);
   localparam int C  = N_INPUTS / LANES;
   localparam int CW = (C > 1) ? $clog2(C) : 1;
   localparam logic [CW-1:0] LAST = CW'(C - 1);

   if ((N_INPUTS % LANES) != 0) begin : g_lanes_check
      $error("neuron_seq: LANES must divide N_INPUTS");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [W_WIDTH-1:0]   w_q [0:N_INPUTS];
   logic [N_INPUTS-1:0]  x_q, x_d;
   logic [W_WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        idx_q, idx_d;
   logic                 wr_en;
   logic [LANES-1:0]     lane_x;
   logic [W_WIDTH-1:0]   lane_w [LANES];
   logic [W_WIDTH-1:0]   acc_step;

   function automatic logic [W_WIDTH-1:0] add_step(input logic [W_WIDTH-1:0] a,
                                                   input logic [W_WIDTH-1:0] b);
      logic [W_WIDTH-1:0] s;
      s = a + b;
`ifdef NEURON_SAT_EN
      // Signed overflow only when both operands share a sign the result lacks.
      if ((a[W_WIDTH-1] == b[W_WIDTH-1]) && (s[W_WIDTH-1] != a[W_WIDTH-1])) begin
         s = a[W_WIDTH-1] ? {1'b1, {(W_WIDTH-1){1'b0}}} : {1'b0, {(W_WIDTH-1){1'b1}}};
      end
`endif
      return s;
   endfunction

   assign in_ready    = (state_q == S_IDLE);
   assign w_ready     = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign sum         = acc_q;
   assign predict     = ~acc_q[W_WIDTH-1];
   assign dbg_state_o = state_q;

   assign wr_en = (state_q == S_IDLE) && w_we && (w_addr <= AW'(N_INPUTS));

   // Select the group of LANES inputs/weights addressed by the cycle index.
   always_comb begin
      lane_x = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_w[l] = '0;
      end
      for (int g = 0; g < C; g++) begin
         if (idx_q == CW'(g)) begin
            for (int l = 0; l < LANES; l++) begin
               lane_x[l] = x_q[g*LANES + l];
               lane_w[l] = w_q[g*LANES + l + 1];
            end
         end
      end
   end

   always_comb begin
      acc_step = acc_q;
      for (int l = 0; l < LANES; l++) begin
         if (lane_x[l]) begin
            acc_step = add_step(acc_step, lane_w[l]);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (in_valid) state_d = S_ACC;
         S_ACC:  if (idx_q == LAST) state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      x_d   = x_q;
      acc_d = acc_q;
      idx_d = idx_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // Bias read here is the pre-write value if a write lands on the same edge.
               x_d   = x;
               acc_d = w_q[0];
               idx_d = '0;
            end
         end
         S_ACC: begin
            acc_d = acc_step;
            if (idx_q != LAST) idx_d = idx_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q   <= '0;
         acc_q <= '0;
         idx_q <= '0;
      end else begin
         x_q   <= x_d;
         acc_q <= acc_d;
         idx_q <= idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= N_INPUTS; k++) begin
            w_q[k] <= '0;
         end
      end else if (wr_en) begin
         w_q[w_addr] <= w_data;
      end
   end

   a_result_stable: assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> ($stable(sum) && out_valid));
   a_no_overlap: assert property (@(posedge clk) disable iff (rst)
      !(in_ready && out_valid));

endmodule

// File: tb/tb_neuron_seq.sv
// Directed bench for neuron_seq: LANES=1 instance plus a LANES=3 instance, scoreboard-checked results.
module tb_neuron_seq;

   logic       clk = 1'b0;
   logic       rst;
   always #5 clk = ~clk;

   logic       w_we, w_ready, in_valid, in_ready, out_valid, out_ready, predict;
   logic [3:0] w_addr;
   logic [7:0] w_data, sum;
   logic [8:0] x;
   logic [1:0] dbg_state;

   logic       b_w_we, b_w_ready, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_predict;
   logic [3:0] b_w_addr;
   logic [7:0] b_w_data, b_sum;
   logic [8:0] b_x;
   logic [1:0] b_dbg_state;

   neuron_seq #(.N_INPUTS(9), .W_WIDTH(8), .LANES(1)) dut (
      .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
      .in_valid(in_valid), .in_ready(in_ready), .x(x), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .predict(predict), .dbg_state_o(dbg_state)
   );

   neuron_seq #(.N_INPUTS(9), .W_WIDTH(8), .LANES(3)) dut3 (
      .clk(clk), .rst(rst), .w_we(b_w_we), .w_addr(b_w_addr), .w_data(b_w_data),
      .w_ready(b_w_ready), .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .sum(b_sum), .predict(b_predict),
      .dbg_state_o(b_dbg_state)
   );

   int         n_checks = 0;
   int         n_pass = 0;
   logic [8:0] exp_q[$];
   logic [8:0] exp3_q[$];
   logic [8:0] e_main, e_three;
   int         cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_w(input logic [3:0] a, input logic [7:0] d);
      w_we = 1'b1; w_addr = a; w_data = d;
      tick();
      w_we = 1'b0;
   endtask

   task automatic accept(input logic [8:0] xv);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1; x = xv;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int c);
      c = 0;
      while (!out_valid && c < 50) begin
         tick();
         c++;
      end
      check("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   // Monitors: pop expected {predict,sum} on every output handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_output", 32'(exp_q.size()), 32'd1);
         else begin
            e_main = exp_q.pop_front();
            check("result", 32'({predict, sum}), 32'(e_main));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b_out_valid && b_out_ready) begin
         if (exp3_q.size() == 0) check("unexpected_output_l3", 32'(exp3_q.size()), 32'd1);
         else begin
            e_three = exp3_q.pop_front();
            check("result_l3", 32'({b_predict, b_sum}), 32'(e_three));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0; in_valid = 1'b0; x = '0; out_ready = 1'b1;
      b_w_we = 1'b0; b_w_addr = '0; b_w_data = '0; b_in_valid = 1'b0; b_x = '0; b_out_ready = 1'b1;
      repeat (2) tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_w_ready", 32'(w_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_predict", 32'(predict), 32'd1);
      rst = 1'b0;

      // all-ones vector, bias 5, unit weights
      write_w(4'd0, 8'h05);
      for (int k = 1; k <= 9; k++) write_w(4'(k), 8'h01);
      exp_q.push_back({1'b1, 8'h0E});
      accept(9'h1FF);
      check("in_ready_during_acc", 32'(in_ready), 32'd0);
      wait_done(cyc);
      check("latency", 32'(cyc), 32'd9);
      tick();

      // negative bias, stalled downstream, second vector pending
      write_w(4'd0, 8'h80);
      out_ready = 1'b0;
      exp_q.push_back({1'b0, 8'h80});
      accept(9'h000);
      wait_done(cyc);
      check("latency_stall", 32'(cyc), 32'd9);
      in_valid = 1'b1; x = 9'h1FF;
      repeat (5) begin
         tick();
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_sum", 32'(sum), 32'h80);
         check("stall_predict", 32'(predict), 32'd0);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("idle_after_handshake", 32'(in_ready), 32'd1);
      check("out_valid_after_handshake", 32'(out_valid), 32'd0);
      exp_q.push_back({1'b0, 8'h89});
      tick();
      in_valid = 1'b0;
      check("second_vector_accepted", 32'(in_ready), 32'd0);
      wait_done(cyc);
      tick();

      // positive overflow boundary
      write_w(4'd0, 8'h7F);
`ifdef NEURON_SAT_EN
      exp_q.push_back({1'b1, 8'h7F});
`else
      exp_q.push_back({1'b0, 8'h80});
`endif
      accept(9'h001);
      wait_done(cyc);
      tick();

      // write during ACC is ignored
      write_w(4'd0, 8'h20);
      exp_q.push_back({1'b1, 8'h21});
      accept(9'h004);
      w_we = 1'b1; w_addr = 4'd3; w_data = 8'h40;
      check("w_ready_in_acc", 32'(w_ready), 32'd0);
      tick();
      w_we = 1'b0;
      wait_done(cyc);
      tick();
      write_w(4'd3, 8'h10);
      exp_q.push_back({1'b1, 8'h30});
      accept(9'h004);
      wait_done(cyc);
      tick();

      // write and accept on the same edge: vector sees old bias
      w_we = 1'b1; w_addr = 4'd0; w_data = 8'h50; in_valid = 1'b1; x = 9'h000;
      exp_q.push_back({1'b1, 8'h20});
      tick();
      w_we = 1'b0; in_valid = 1'b0;
      wait_done(cyc);
      tick();
      exp_q.push_back({1'b1, 8'h50});
      accept(9'h000);
      wait_done(cyc);
      tick();

      // out-of-range addresses must not disturb the register file
      write_w(4'd10, 8'h33);
      write_w(4'd15, 8'h44);
      exp_q.push_back({1'b1, 8'h68});
      accept(9'h1FF);
      wait_done(cyc);
      tick();

      // reset in the middle of accumulation
      accept(9'h1FF);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_predict", 32'(predict), 32'd1);
      rst = 1'b0;
      exp_q.push_back({1'b1, 8'h00});
      accept(9'h1FF);
      wait_done(cyc);
      tick();

      // LANES=3 instance
      for (int k = 0; k <= 9; k++) begin
         b_w_we = 1'b1; b_w_addr = 4'(k); b_w_data = (k == 0) ? 8'h05 : 8'h01;
         tick();
      end
      b_w_we = 1'b0;
      exp3_q.push_back({1'b1, 8'h0E});
      b_in_valid = 1'b1; b_x = 9'h1FF;
      tick();
      b_in_valid = 1'b0;
      cyc = 0;
      while (!b_out_valid && cyc < 50) begin
         tick();
         cyc++;
      end
      check("latency_l3", 32'(cyc), 32'd3);
      tick();

      repeat (2) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("queue_drained_l3", 32'(exp3_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
